tick_bcd_display: RTL and testbench
===================================

Name: tick_bcd_display

Overview:
- Consumes the slow square wave produced by the clock divider stage (for example the 7 Hz output) as a count-enable `tick_in`.
- Steps a 4-digit BCD up/down counter on each rising edge of `tick_in`.
- Drives a multiplexed 4-digit 7-segment display on the board.
- Fully synchronous to the 100 MHz system clock `clock_in`; `tick_in` is never used as a clock.

Parameters:
- SCAN_DIV, 100000, `clock_in` cycles per displayed digit (1 kHz digit rate at 100 MHz); legal range ≥2.
- SCAN_W, 17, width of the scan counter; must satisfy 2^SCAN_W ≥ SCAN_DIV.

Ports:
- clock_in  input  1   system clock, 100 MHz
- reset_n  input  1   synchronous active-low reset, sampled on the rising edge of `clock_in`
- tick_in  input  1   slow square wave from the divider, registered in the `clock_in` domain
- enable  input  1   1 = counting allowed
- up_down  input  1   1 = count up, 0 = count down
- clear  input  1   synchronous clear of the count
- count_bcd  output  16  {d3,d2,d1,d0}, d0 least significant, each digit BCD 0-9
- wrap  output  1   one-cycle pulse on 9999→0000 (up) or 0000→9999 (down)
- seg  output  7   active-low segments, bit order {g,f,e,d,c,b,a}
- an  output  4   active-low digit enables; an[i] selects digit di

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - count_bcd=16'h0000, wrap=0, scan counter=0, digit index=0.
  - an=4'b1110, seg=7'b1000000 (digit "0").
  - tick_q=1, so a tick_in already high at release does not cause a step.
- Edge detect: tick_q <= tick_in every cycle; step = tick_in & ~tick_q.
- Count update, evaluated at each clock edge in priority order:
  1. clear=1: count=0000, wrap=0. Clear ignores enable and any coincident step.
  2. step & enable, up_down=1: BCD increment; a digit at 9 becomes 0 and carries to the next digit; 9999→0000 with wrap=1.
  3. step & enable, up_down=0: BCD decrement; a digit at 0 becomes 9 and borrows from the next digit; 0000→9999 with wrap=1.
  4. Otherwise: count holds, wrap=0.
- Latency: count_bcd changes at the first clock edge where tick_in=1 is sampled with tick_q=0, i.e. 1 cycle after tick_in rises.
- Exactly one step per tick_in rising edge regardless of tick_in high time. A tick_in high for one cycle is still a valid edge.
- wrap is registered and high for exactly one cycle, only on a wrap step.
- Digit scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously and is independent of enable and clear.
  - At terminal count it returns to 0 and the digit index advances 0→1→2→3→0.
- Display outputs:
  - an and seg are registered.
  - an = ~(4'b0001 << index).
  - seg = decode(count_bcd digit[index]).
  - Both reflect the current index and count one cycle after either changes.
  - Both update on the same edge, so there is no ghosting glitch.
- Decode table (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD codes (unreachable) give 1111111 (blank).
- Reset mid-operation overrides everything on that edge. No pending step survives reset.
- Counter digits never hold non-BCD values.

Decomposition:
- Shared package:
  - SEG_* constants for digits 0-9 and SEG_BLANK.
  - Digit-count constant NUM_DIGITS=4.
  - BCD digit typedef (4-bit).
- One natural sub-module: seg7_decoder, a combinational BCD→active-low segment lookup, reusable by other display blocks.
- The BCD counter chain stays inline.

Test Plan:
- Reset with tick_in held 1 for 3 cycles, then release and keep tick_in=1 → count_bcd=0000, an=1110, seg=1000000, no step, wrap=0.
- enable=1, up_down=1, 12 tick_in pulses (2 cycles high / 2 low) → count_bcd=16'h0012; each step lands 1 cycle after a rising edge.
- From 0000, up_down=0, one tick → count_bcd=16'h9999 with wrap=1 for exactly one cycle. Then 10 more up ticks after a count of 9995 gives 9999→0000 with a wrap pulse.
- clear=1 in the same cycle as a step edge from count 0057 → count_bcd=0000, wrap=0. With enable=0, 5 ticks → count unchanged.
- SCAN_DIV=4, count=0012 → an cycles 1110,1101,1011,0111, each held 4 cycles. seg=0100100 while an=1110, 1111001 while an=1101, 1000000 for the two upper digits.

Source files
------------

// File: rtl/tick_bcd_display_pkg.sv
// tick_bcd_display_pkg: shared digit type and active-low 7-segment patterns
// Bit order of every SEG_* pattern is {g,f,e,d,c,b,a}; 0 lights a segment.
package tick_bcd_display_pkg;
   localparam int NUM_DIGITS = 4;
   typedef logic [3:0] bcd_t;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/tick_bcd_display_seg7_decoder.sv
// seg7_decoder: combinational BCD digit to active-low 7-segment lookup
// Ports: digit - BCD input; seg - active-low {g,f,e,d,c,b,a}, blank for non-BCD codes
module seg7_decoder
   import tick_bcd_display_pkg::*;
(
   input  bcd_t       digit,
   output logic [6:0] seg
);
   always_comb begin
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/tick_bcd_display.sv
// tick_bcd_display: tick-driven 4-digit BCD up/down counter with multiplexed 7-segment output
// Ports: clock_in/reset_n (sync, active low); tick_in is a slow wave used only as an enable;
// enable/up_down/clear control counting; count_bcd {d3,d2,d1,d0}; wrap pulses on rollover;
// seg (active-low gfedcba) and an (active-low digit select) drive the display.
module tick_bcd_display
   import tick_bcd_display_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int SCAN_W   = 17
) (
   input  logic              clock_in,
   input  logic              reset_n,
   input  logic              tick_in,
   input  logic              enable,
   input  logic              up_down,
   input  logic              clear,
   output logic [15:0]       count_bcd,
   output logic              wrap,
   output logic [6:0]        seg,
   output logic [3:0]        an
);
   logic              tick_q;
   logic [15:0]       count_q, count_d, inc_v, dec_v;
   logic              wrap_q, wrap_d;
   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              step, cy, bw, term;
   bcd_t              d;

   seg7_decoder u_dec (.digit(count_q[{idx_q, 2'b00} +: 4]), .seg(seg_d));

   // Ripple carry/borrow: cy/bw stay set only while every lower digit was 9/0,
   // so after the loop they also flag the full-range wrap.
   always_comb begin
      inc_v = count_q;
      dec_v = count_q;
      cy    = 1'b1;
      bw    = 1'b1;
      d     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d            = count_q[4*i +: 4];
         inc_v[4*i +: 4] = cy ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
         dec_v[4*i +: 4] = bw ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
         cy           = cy & (d == 4'd9);
         bw           = bw & (d == 4'd0);
      end
   end

   always_comb begin
      step    = tick_in & ~tick_q;
      count_d = clear ? 16'h0000 : (step & enable) ? (up_down ? inc_v : dec_v) : count_q;
      wrap_d  = ~clear & step & enable & (up_down ? cy : bw);
      term    = (scan_q == SCAN_W'(SCAN_DIV - 1));
      scan_d  = term ? '0 : scan_q + SCAN_W'(1);
      idx_d   = term ? idx_q + 2'd1 : idx_q;
      an_d    = ~(4'b0001 << idx_q);
   end

   // tick_q resets high so a tick_in already high at release is not an edge.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         tick_q  <= 1'b1;
         count_q <= 16'h0000;
         wrap_q  <= 1'b0;
         scan_q  <= '0;
         idx_q   <= 2'd0;
         an_q    <= 4'b1110;
         seg_q   <= SEG_0;
      end else begin
         tick_q  <= tick_in;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign count_bcd = count_q;
   assign wrap      = wrap_q;
   assign seg       = seg_q;
   assign an        = an_q;
endmodule

// File: tb/tb_tick_bcd_display.sv
// tb_tick_bcd_display: directed self-checking bench for tick_bcd_display
module tb_tick_bcd_display;
   logic        clk = 1'b0;
   logic        reset_n, tick_in, enable, up_down, clear;
   logic [15:0] count_bcd;
   logic        wrap;
   logic [6:0]  seg;
   logic [3:0]  an;
   int          checks = 0;
   int          failures = 0;

   tick_bcd_display #(.SCAN_DIV(4), .SCAN_W(2)) dut (
      .clock_in(clk), .reset_n(reset_n), .tick_in(tick_in), .enable(enable),
      .up_down(up_down), .clear(clear), .count_bcd(count_bcd), .wrap(wrap),
      .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         tick_in = 1'b1;
         repeat (2) @(negedge clk);
         tick_in = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_an [4];
      logic [6:0] exp_seg [4];
      logic [3:0] prev_an;
      bit         found;
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'b0100100, 7'b1111001, 7'b1000000, 7'b1000000};

      reset_n = 1'b0; tick_in = 1'b1; enable = 1'b0; up_down = 1'b1; clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_count", count_bcd, 16'h0000);
      chk("reset_wrap", {15'd0, wrap}, 16'd0);
      chk("reset_an", {12'd0, an}, 16'h000E);
      chk("reset_seg", {9'd0, seg}, {9'd0, 7'b1000000});
      reset_n = 1'b1;
      enable  = 1'b1;
      repeat (2) @(negedge clk);
      chk("release_no_step", count_bcd, 16'h0000);
      chk("release_wrap", {15'd0, wrap}, 16'd0);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);

      tick_in = 1'b1;
      @(negedge clk);
      chk("latency_one_cycle", count_bcd, 16'h0001);
      @(negedge clk);
      chk("one_step_per_edge", count_bcd, 16'h0001);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      pulses(11);
      chk("up_12", count_bcd, 16'h0012);
      chk("up_12_wrap", {15'd0, wrap}, 16'd0);

      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      @(negedge clk);
      chk("one_cycle_high_tick", count_bcd, 16'h0013);

      do_clear();
      chk("clear_zero", count_bcd, 16'h0000);
      up_down = 1'b0;
      tick_in = 1'b1;
      @(negedge clk);
      chk("down_wrap_count", count_bcd, 16'h9999);
      chk("down_wrap_pulse", {15'd0, wrap}, 16'd1);
      @(negedge clk);
      chk("down_wrap_one_cycle", {15'd0, wrap}, 16'd0);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      pulses(4);
      chk("down_9995", count_bcd, 16'h9995);
      up_down = 1'b1;
      pulses(4);
      chk("up_9999", count_bcd, 16'h9999);
      tick_in = 1'b1;
      @(negedge clk);
      chk("up_wrap_count", count_bcd, 16'h0000);
      chk("up_wrap_pulse", {15'd0, wrap}, 16'd1);
      @(negedge clk);
      chk("up_wrap_one_cycle", {15'd0, wrap}, 16'd0);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      pulses(5);
      chk("up_after_wrap", count_bcd, 16'h0005);

      do_clear();
      pulses(57);
      chk("count_57", count_bcd, 16'h0057);
      clear   = 1'b1;
      tick_in = 1'b1;
      @(negedge clk);
      chk("clear_beats_step", count_bcd, 16'h0000);
      chk("clear_no_wrap", {15'd0, wrap}, 16'd0);
      clear = 1'b0;
      @(negedge clk);
      chk("no_step_after_clear", count_bcd, 16'h0000);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      pulses(3);
      chk("count_3", count_bcd, 16'h0003);
      enable = 1'b0;
      pulses(5);
      chk("disabled_hold", count_bcd, 16'h0003);
      enable = 1'b1;

      tick_in = 1'b1;
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_reset", count_bcd, 16'h0000);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("no_pending_step", count_bcd, 16'h0000);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);

      pulses(12);
      chk("scan_count_12", count_bcd, 16'h0012);
      found   = 1'b0;
      prev_an = an;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found   = (an == 4'b1110) && (prev_an != 4'b1110);
         prev_an = an;
      end
      chk("scan_sync_found", {15'd0, found}, 16'd1);
      for (int dg = 0; dg < 4; dg++) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("an_d%0d_c%0d", dg, k), {12'd0, an}, {12'd0, exp_an[dg]});
            chk($sformatf("seg_d%0d_c%0d", dg, k), {9'd0, seg}, {9'd0, exp_seg[dg]});
            @(negedge clk);
         end
      end
      chk("scan_back_to_d0", {12'd0, an}, 16'h000E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
